// File: rtl/sine_pwm_pkg.sv
// sine_pwm_pkg: shared constants, types and duty scaling for the sine PWM generator.
//   SINE_LUT        32-entry, 8-bit sine table centred on 128
//   LUT_ADDR_WIDTH  number of phase bits used to address SINE_LUT
//   dir_e           triangle-carrier count direction
//   scale_duty      duty = 2^(pw-1) + (((lut-128) << (pw-8)) * amp >>> pw)
package sine_pwm_pkg;

   localparam int LUT_ADDR_WIDTH = 5;

   localparam logic [7:0] SINE_LUT [32] = '{
      8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
      8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
      8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
      8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
   };

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   // Evaluated in 64-bit signed arithmetic so the product never overflows for
   // any practical carrier width; the caller keeps the low pw bits.
   function automatic logic signed [63:0] scale_duty(
      input logic [7:0]  lut,
      input logic [31:0] amp,
      input int          pw
   );
      logic signed [63:0] s;
      logic signed [63:0] p;
      s = $signed({56'd0, lut}) - 64'sd128;
      s = s <<< (pw - 8);
      p = s * $signed({32'd0, amp});
      return (64'sd1 <<< (pw - 1)) + (p >>> pw);
   endfunction

endpackage

// File: rtl/sine_pwm_carrier.sv
// sine_pwm_carrier: prescaler, carrier counter and period boundary generation.
//   clk            system clock
//   rst_n          synchronous active-low reset
//   i_enable       run (1) / hold counters at 0 (0)
//   i_prescale     carrier advances every i_prescale+1 cycles
//   o_carrier      carrier register
//   o_boundary     combinational: this tick ends the carrier period
//   o_period_start registered pulse on the first cycle of each period
// SINE_PWM_CENTER_ALIGNED_EN selects a triangle carrier instead of a sawtooth.
module sine_pwm_carrier
   import sine_pwm_pkg::*;
#(
   parameter int PWM_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_enable,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   output logic [PWM_WIDTH-1:0]      o_carrier,
   output logic                      o_boundary,
   output logic                      o_period_start
);

   localparam logic [PWM_WIDTH-1:0] CARRIER_MAX = '1;

   logic [PRESCALE_WIDTH-1:0] r_pre;
   logic [PWM_WIDTH-1:0]      r_carrier;
   logic                      r_period_start;
   logic                      w_tick;

   assign w_tick = i_enable && (r_pre == i_prescale);

`ifdef SINE_PWM_CENTER_ALIGNED_EN
   dir_e r_dir;

   // The tick that leaves 0 on the way down closes the period; the carrier then
   // climbs to 1, so 0 is visited once per period.
   assign o_boundary = w_tick && (r_dir == DIR_DOWN) && (r_carrier == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || !i_enable) begin
         r_pre          <= '0;
         r_carrier      <= '0;
         r_dir          <= DIR_UP;
         r_period_start <= 1'b0;
      end else begin
         r_pre          <= w_tick ? '0 : r_pre + PRESCALE_WIDTH'(1);
         r_period_start <= o_boundary;
         if (w_tick) begin
            if (r_dir == DIR_UP) begin
               r_dir     <= (r_carrier == CARRIER_MAX) ? DIR_DOWN : DIR_UP;
               r_carrier <= (r_carrier == CARRIER_MAX) ? r_carrier - PWM_WIDTH'(1)
                                                       : r_carrier + PWM_WIDTH'(1);
            end else begin
               r_dir     <= (r_carrier == '0) ? DIR_UP : DIR_DOWN;
               r_carrier <= (r_carrier == '0) ? PWM_WIDTH'(1) : r_carrier - PWM_WIDTH'(1);
            end
         end
      end
   end
`else
   assign o_boundary = w_tick && (r_carrier == CARRIER_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n || !i_enable) begin
         r_pre          <= '0;
         r_carrier      <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_pre          <= w_tick ? '0 : r_pre + PRESCALE_WIDTH'(1);
         r_carrier      <= w_tick ? r_carrier + PWM_WIDTH'(1) : r_carrier;
         r_period_start <= o_boundary;
      end
   end
`endif

   assign o_carrier      = r_carrier;
   assign o_period_start = r_period_start;

endmodule

// File: rtl/sine_pwm_multi.sv
// sine_pwm_multi: multi-channel sine-modulated PWM with boundary-synchronous config.
//   clk, rst_n     clock, synchronous active-low reset
//   enable         run (1) / idle (0)
//   cfg_valid/cfg_ready  config handshake; a word is held in a shadow until the
//                  next carrier boundary (or the next cycle while idle)
//   cfg_prescale   carrier advances every cfg_prescale+1 cycles
//   cfg_freq       phase increment per carrier period
//   cfg_amp        modulation depth
//   cfg_offset     per-channel phase offset, channel c at [c*PHASE_WIDTH +: PHASE_WIDTH]
//   pwm_out        registered PWM outputs
//   period_start   one-cycle pulse on the first cycle of each carrier period
// SINE_PWM_CENTER_ALIGNED_EN (in sine_pwm_carrier) selects a triangle carrier.
module sine_pwm_multi
   import sine_pwm_pkg::*;
#(
   parameter int PWM_WIDTH      = 8,
   parameter int PHASE_WIDTH    = 16,
   parameter int NUM_CH         = 3,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [PRESCALE_WIDTH-1:0]     cfg_prescale,
   input  logic [PHASE_WIDTH-1:0]        cfg_freq,
   input  logic [PWM_WIDTH-1:0]          cfg_amp,
   input  logic [NUM_CH*PHASE_WIDTH-1:0] cfg_offset,
   output logic [NUM_CH-1:0]             pwm_out,
   output logic                          period_start
);

   logic                          r_pending;
   logic [PRESCALE_WIDTH-1:0]     r_sh_prescale, r_prescale;
   logic [PHASE_WIDTH-1:0]        r_sh_freq, r_freq;
   logic [PWM_WIDTH-1:0]          r_sh_amp, r_amp;
   logic [NUM_CH*PHASE_WIDTH-1:0] r_sh_offset, r_offset;
   logic [PHASE_WIDTH-1:0]        r_phase;

   logic [PWM_WIDTH-1:0]          w_carrier;
   logic                          w_boundary;
   logic                          w_accept;
   logic                          w_apply;
   logic [PHASE_WIDTH-1:0]        w_freq;
   logic [PWM_WIDTH-1:0]          w_amp;
   logic [NUM_CH*PHASE_WIDTH-1:0] w_offset;

   sine_pwm_carrier #(
      .PWM_WIDTH      (PWM_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_carrier (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_enable       (enable),
      .i_prescale     (r_prescale),
      .o_carrier      (w_carrier),
      .o_boundary     (w_boundary),
      .o_period_start (period_start)
   );

   assign cfg_ready = ~r_pending;
   assign w_accept  = cfg_valid && !r_pending;
   assign w_apply   = r_pending && (w_boundary || !enable);

   // On the boundary that promotes the shadow, the duty loaded for the coming
   // period already uses the new settings.
   assign w_freq   = w_apply ? r_sh_freq   : r_freq;
   assign w_amp    = w_apply ? r_sh_amp    : r_amp;
   assign w_offset = w_apply ? r_sh_offset : r_offset;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending     <= 1'b0;
         r_sh_prescale <= '0;
         r_sh_freq     <= '0;
         r_sh_amp      <= '0;
         r_sh_offset   <= '0;
         r_prescale    <= '0;
         r_freq        <= '0;
         r_amp         <= '0;
         r_offset      <= '0;
         r_phase       <= '0;
      end else begin
         if (w_accept) begin
            r_sh_prescale <= cfg_prescale;
            r_sh_freq     <= cfg_freq;
            r_sh_amp      <= cfg_amp;
            r_sh_offset   <= cfg_offset;
            r_pending     <= 1'b1;
         end else if (w_apply) begin
            r_prescale <= r_sh_prescale;
            r_freq     <= r_sh_freq;
            r_amp      <= r_sh_amp;
            r_offset   <= r_sh_offset;
            r_pending  <= 1'b0;
         end
         if (w_boundary)
            r_phase <= r_phase + w_freq;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [LUT_ADDR_WIDTH-1:0] w_addr;
      logic [PWM_WIDTH-1:0]      r_duty;
      logic                      r_pwm;

      // Table address is the top bits of the pre-update phase plus this channel's offset.
      assign w_addr = LUT_ADDR_WIDTH'((PHASE_WIDTH'(r_phase + w_offset[c*PHASE_WIDTH +: PHASE_WIDTH]))
                                      >> (PHASE_WIDTH - LUT_ADDR_WIDTH));

      always_ff @(posedge clk) begin
         if (!rst_n)
            r_duty <= '0;
         else if (w_boundary)
            r_duty <= PWM_WIDTH'(scale_duty(SINE_LUT[w_addr], 32'(w_amp), PWM_WIDTH));
      end

      always_ff @(posedge clk) begin
         if (!rst_n || !enable)
            r_pwm <= 1'b0;
         else
            r_pwm <= r_duty > w_carrier;
      end

      assign pwm_out[c] = r_pwm;
   end

endmodule

// File: doc/sine_pwm_multi.md
# sine_pwm_multi

Multi-channel sine-modulated PWM generator: a shared carrier, per-channel phase offsets (e.g. 3-phase at 120°), programmable modulation frequency, amplitude scaling and carrier prescaler. Configuration changes arrive through a valid/ready handshake and are applied only at a carrier period boundary, so the outputs never glitch. It sits between the control/register logic and the gate-drive pins, replacing the single-channel fixed-rate sine PWM generator.

## Interface
- PWM_WIDTH, 8, carrier/duty width; must be ≥ 8.
- PHASE_WIDTH, 16, phase accumulator width; must be ≥ 5.
- NUM_CH, 3, number of PWM channels.
- PRESCALE_WIDTH, 8, width of the carrier prescaler.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run (1) / idle (0).
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
- cfg_prescale  in  PRESCALE_WIDTH  carrier advances every cfg_prescale+1 cycles.
- cfg_freq  in  PHASE_WIDTH  phase increment per carrier period.
- cfg_amp  in  PWM_WIDTH  modulation depth; 0 = flat 50 %, max = full scale.
- cfg_offset  in  NUM_CH*PHASE_WIDTH  per-channel phase offset; channel c at bits [c*PHASE_WIDTH +: PHASE_WIDTH].
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse, first cycle of each carrier period.

## Operation
- Tick: prescale counter counts 0..prescale_active, then wraps. It emits a tick on the wrap; prescale 0 ⇒ tick every cycle.
- Carrier: sawtooth that increments on each tick and wraps from 2^PWM_WIDTH−1 to 0. A boundary is a tick with carrier = max.
- At each boundary:
  - phase_acc ← phase_acc + freq_active (mod 2^PHASE_WIDTH).
  - For each channel c: addr = top 5 bits of (phase_acc + offset_active[c]), using the pre-update phase_acc.
  - lut = SINE_LUT[addr].
  - s = (lut − 128) signed, shifted left by PWM_WIDTH−8.
  - duty[c] ← 2^(PWM_WIDTH−1) + ((s · amp_active) >>> PWM_WIDTH), computed as a full-width signed product.
- SINE_LUT, 32 entries, 8 bit: 128,153,177,199,218,234,245,253,255,253,245,234,218,199,177,153,128,103,79,57,38,22,11,3,1,3,11,22,38,57,79,103.
- pwm_out[c] ← (duty[c] > carrier) every cycle.
- Config handshake:
  - cfg_ready = ~pending.
  - On accept, all cfg_* inputs are copied to a shadow register and pending is set.
  - At the next boundary, shadow → active and pending is cleared.
  - An accept in the same cycle as a boundary applies at the following boundary.
- enable = 0:
  - Prescale counter and carrier held at 0; phase_acc held; pwm_out forced 0; period_start 0.
  - A pending shadow is applied on the next cycle.
  - When enable returns to 1, the carrier restarts at 0; duty keeps its last value.
- Reset mid-operation returns all state to reset values on the next edge. Any pending config is discarded.

## Timing
- Reset values:
  - Outputs: pwm_out = 0, period_start = 0, cfg_ready = 1.
  - Internal state: carrier, prescale counter, phase_acc, duty and pending all 0; active config all 0.
- The duty load and the carrier wrap to 0 happen on the same edge, so the first compare of a new period uses the new duty.
- pwm_out lags the carrier register by 1 cycle.
- period_start is registered and asserts on the edge where the carrier becomes 0 after a boundary.
- Sawtooth period = 2^PWM_WIDTH · (prescale+1) cycles.

## Configuration
- SINE_PWM_CENTER_ALIGNED_EN defined:
  - Triangle carrier: counts up 0 → max, then down to 0.
  - Boundary is a tick at carrier 0 while counting down.
  - Period = 2·(2^PWM_WIDTH−1)·(prescale+1) cycles.
  - Compare rule unchanged.
- Undefined: sawtooth as above.

## Structure
- Package sine_pwm_pkg holds SINE_LUT, LUT_ADDR_WIDTH = 5 and the duty-scaling function.
- Sub-module sine_pwm_carrier holds the prescaler, carrier and boundary/period_start generation, and contains the SINE_PWM_CENTER_ALIGNED_EN logic.
- The top level holds the handshake, phase accumulator and per-channel duty/compare generate loop.

## Test plan
All scenarios use default parameters.
- Reset: rst_n low 3 cycles mid-run → pwm_out = 000, period_start = 0, cfg_ready = 1 on the following cycle.
- freq = 0, amp = 255, prescale = 0 → after the first boundary, each channel is high for 128 of every 256 cycles; period_start spacing is 256.
- amp = 0, freq = 0x0800 → duty stays 128 on all channels for every period.
- freq = 0x0800, amp = 255, offsets 0/0x5555/0xAAAA, with 0x0800 giving one LUT step per period → at the 9th boundary from phase 0 (phase_acc = 0x4000) channel 0 loads duty 254 (lut 255). Channel 1 and channel 2 duties follow the same formula at their offset addresses.
- cfg_valid pulse mid-period → cfg_ready low from the next cycle; duty unchanged until the boundary; new values in effect from the following period; cfg_ready high after the boundary.
- prescale = 3 → carrier steps every 4 cycles; period_start spacing is 1024 cycles. With SINE_PWM_CENTER_ALIGNED_EN, the spacing is 2040.
